// File: rtl/conv_pkg.sv
// Shared types for the convolution MAC sequencer: FSM states, default MAC depth, counter widths.
// Pure declarations; no timing or flow control of its own.
package conv_pkg;

    typedef enum logic [2:0] {IDLE, INIT, ISSUE, DRAIN, OUT, DONE} conv_state_t;

    localparam int MULT_LAT_DEFAULT = 4;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Output-pixel and filter-tap walker producing row-major image/filter SRAM addresses.
// Addresses register on the step edge; they hold whenever no step/clear is asserted.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_H = 8,
    parameter int IMG_W = 8,
    parameter int K     = 3,
    parameter int XAW   = $clog2(IMG_H*IMG_W),
    parameter int FAW   = $clog2(K*K)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear_taps,
    input  logic           step_tap,
    input  logic           step_pixel,
    output logic [XAW-1:0] x_addr,
    output logic [FAW-1:0] f_addr,
    output logic           last_tap,
    output logic           last_pixel
);

    localparam int KW  = cnt_w(K);
    localparam int ORW = cnt_w(IMG_H-K+1);
    localparam int OCW = cnt_w(IMG_W-K+1);
    localparam logic [XAW-1:0] ROW_STRIDE = XAW'(IMG_W);
    localparam logic [XAW-1:0] TAP_WRAP   = XAW'(IMG_W-K+1);

    logic [KW-1:0]  fr, fc;
    logic [ORW-1:0] orow;
    logic [OCW-1:0] ocol;
    logic [XAW-1:0] row_base, pix_base;

    assign last_tap   = (fr == KW'(K-1)) && (fc == KW'(K-1));
    assign last_pixel = (orow == ORW'(IMG_H-K)) && (ocol == OCW'(IMG_W-K));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fr       <= '0;
            fc       <= '0;
            orow     <= '0;
            ocol     <= '0;
            row_base <= '0;
            pix_base <= '0;
            x_addr   <= '0;
            f_addr   <= '0;
        end else begin
            if (clear_taps) begin
                fr     <= '0;
                fc     <= '0;
                x_addr <= pix_base;
                f_addr <= '0;
            end else if (step_tap && !last_tap) begin
                f_addr <= f_addr + 1'b1;
                if (fc == KW'(K-1)) begin
                    // jump from the end of one window row to the start of the next
                    fc     <= '0;
                    fr     <= fr + 1'b1;
                    x_addr <= x_addr + TAP_WRAP;
                end else begin
                    fc     <= fc + 1'b1;
                    x_addr <= x_addr + 1'b1;
                end
            end
            if (step_pixel) begin
                if (last_pixel) begin
                    orow     <= '0;
                    ocol     <= '0;
                    row_base <= '0;
                    pix_base <= '0;
                end else if (ocol == OCW'(IMG_W-K)) begin
                    ocol     <= '0;
                    orow     <= orow + 1'b1;
                    row_base <= row_base + ROW_STRIDE;
                    pix_base <= row_base + ROW_STRIDE;
                end else begin
                    ocol     <= ocol + 1'b1;
                    pix_base <= pix_base + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequences one 2D convolution through a pipelined MAC, one output pixel at a time.
// Pixel period 1+K*K+MULT_LAT+2+1 cycles; y_valid holds with y_data frozen until y_ready.
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int INW      = 24,
    parameter int OUTW     = 48,
    parameter int IMG_H    = 8,
    parameter int IMG_W    = 8,
    parameter int K        = 3,
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int XAW      = $clog2(IMG_H*IMG_W),
    parameter int FAW      = $clog2(K*K)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [INW-1:0]  bias,
    output logic [XAW-1:0]  x_addr,
    input  logic [INW-1:0]  x_data,
    output logic [FAW-1:0]  f_addr,
    input  logic [INW-1:0]  f_data,
    output logic [INW-1:0]  mac_input0,
    output logic [INW-1:0]  mac_input1,
    output logic [INW-1:0]  mac_init_value,
    output logic            mac_init_acc,
    output logic            mac_input_valid,
    input  logic [OUTW-1:0] mac_out,
    output logic [OUTW-1:0] y_data,
    output logic            y_valid,
    input  logic            y_ready
);

    localparam int DW = cnt_w(MULT_LAT+2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MULT_LAT+1);

    conv_state_t   state;
    logic [DW-1:0] drain_cnt;
    logic          rd_v;
    logic          last_tap, last_pixel;

    assign mac_input0      = x_data;
    assign mac_input1      = f_data;
    assign mac_init_value  = bias;
    assign mac_input_valid = rd_v;

    conv_addr_gen #(
        .IMG_H (IMG_H),
        .IMG_W (IMG_W),
        .K     (K),
        .XAW   (XAW),
        .FAW   (FAW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear_taps (state == INIT),
        .step_tap   (state == ISSUE),
        .step_pixel ((state == OUT) && y_ready),
        .x_addr     (x_addr),
        .f_addr     (f_addr),
        .last_tap   (last_tap),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            rd_v         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mac_init_acc <= 1'b0;
            y_valid      <= 1'b0;
            y_data       <= '0;
        end else begin
            // SRAM data arrives one cycle after the address, so valid trails ISSUE by one
            rd_v         <= (state == ISSUE);
            done         <= 1'b0;
            mac_init_acc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= INIT;
                        busy         <= 1'b1;
                        mac_init_acc <= 1'b1;
                    end
                end
                INIT: state <= ISSUE;
                ISSUE: begin
                    if (last_tap) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // spans the last valid cycle plus the full multiplier pipe and one spare
                    if (drain_cnt == DRAIN_LAST) begin
                        state   <= OUT;
                        y_valid <= 1'b1;
                        y_data  <= mac_out;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        if (last_pixel) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state        <= INIT;
                            mac_init_acc <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer: behavioural SRAMs and MAC around the DUT, results checked
// against a direct sum-of-products convolution of the bench's own memory contents.
module tb_conv_mac_sequencer;

    localparam int INW = 24, OUTW = 48, IMG_H = 8, IMG_W = 8, K = 3, MULT_LAT = 4;
    localparam int XAW = 6, FAW = 4;
    localparam int OH = IMG_H-K+1, OW = IMG_W-K+1, NPIX = OH*OW;
    localparam int PERIOD = 1 + K*K + MULT_LAT + 2 + 1;

    logic            clk = 1'b0;
    logic            reset, start, y_ready;
    logic            busy, done, mac_init_acc, mac_input_valid, y_valid;
    logic [INW-1:0]  bias, x_data, f_data, mac_input0, mac_input1, mac_init_value;
    logic [XAW-1:0]  x_addr;
    logic [FAW-1:0]  f_addr;
    logic [OUTW-1:0] mac_out, y_data;

    always #5 clk = ~clk;

    conv_mac_sequencer #(
        .INW(INW), .OUTW(OUTW), .IMG_H(IMG_H), .IMG_W(IMG_W), .K(K),
        .MULT_LAT(MULT_LAT), .XAW(XAW), .FAW(FAW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bias(bias),
        .x_addr(x_addr), .x_data(x_data), .f_addr(f_addr), .f_data(f_data),
        .mac_input0(mac_input0), .mac_input1(mac_input1), .mac_init_value(mac_init_value),
        .mac_init_acc(mac_init_acc), .mac_input_valid(mac_input_valid), .mac_out(mac_out),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
    );

    // Sync-read image and filter memories
    logic signed [INW-1:0] xm [IMG_H*IMG_W];
    logic signed [INW-1:0] fm [K*K];
    always @(posedge clk) begin
        x_data <= xm[x_addr];
        f_data <= fm[f_addr];
    end

    // MAC: product lands in the accumulator MULT_LAT+1 edges after its valid cycle
    logic signed [INW-1:0]  sa, sb, sbias;
    logic signed [OUTW-1:0] prod, acc;
    logic signed [OUTW-1:0] pipe [MULT_LAT];
    logic                   pv   [MULT_LAT];
    assign sa      = mac_input0;
    assign sb      = mac_input1;
    assign sbias   = mac_init_value;
    assign prod    = OUTW'(sa) * OUTW'(sb);
    assign mac_out = acc;
    always @(posedge clk) begin
        pipe[0] <= prod;
        pv[0]   <= mac_input_valid;
        for (int i = 1; i < MULT_LAT; i++) begin
            pipe[i] <= pipe[i-1];
            pv[i]   <= pv[i-1];
        end
        if (mac_init_acc) acc <= OUTW'(sbias);
        else if (pv[MULT_LAT-1] === 1'b1) acc <= acc + pipe[MULT_LAT-1];
    end

    // Passive monitor: handshakes, done pulses, strobe accounting
    logic [OUTW-1:0] yq [$];
    int tq [$];
    int cyc = 0, done_tot = 0, vld_tot = 0, ovl_tot = 0, bd_tot = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (y_valid === 1'b1 && y_ready === 1'b1) begin
            yq.push_back(y_data);
            tq.push_back(cyc);
        end
        if (done === 1'b1) done_tot++;
        if (mac_input_valid === 1'b1) vld_tot++;
        if (mac_init_acc === 1'b1 && mac_input_valid === 1'b1) ovl_tot++;
        if (busy === 1'b1 && done === 1'b1) bd_tot++;
    end

    int n_assert = 0, n_fail = 0;
    int by, bd, bv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUTW-1:0] ref_pix(input int i, input int j);
        longint s = longint'($signed(bias));
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                s += longint'(xm[(i+r)*IMG_W + j + c]) * longint'(fm[r*K + c]);
        return OUTW'(s);
    endfunction

    task automatic fill_random();
        for (int a = 0; a < IMG_H*IMG_W; a++) xm[a] = INW'($urandom);
        for (int a = 0; a < K*K; a++) fm[a] = INW'($urandom);
        bias = INW'($urandom);
    endtask

    task automatic start_run(input string tag);
        by = yq.size();
        bd = done_tot;
        bv = vld_tot;
        chk({tag, "_idle_busy"}, busy, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1'b1);
    endtask

    // mode 0: ready held high; 1: random ready; 2: extra start pulses while busy and in DONE
    task automatic finish_run(input int mode, input string tag);
        int t = 0;
        bit seen = 0;
        while (!seen && t < 4000) begin
            if (mode == 1) y_ready = 1'($urandom_range(0, 1));
            if (mode == 2) start = (t % 41 == 7);
            tick();
            t++;
            if (done === 1'b1) seen = 1;
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_busy_low_at_done"}, busy, 1'b0);
        if (mode == 2) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        y_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_count"}, yq.size() - by, NPIX);
        chk({tag, "_done_pulses"}, done_tot - bd, 1);
        chk({tag, "_valid_beats"}, vld_tot - bv, NPIX*K*K);
        chk({tag, "_strobe_overlap"}, ovl_tot, 0);
        chk({tag, "_busy_with_done"}, bd_tot, 0);
        for (int k = 0; k < NPIX && by + k < yq.size(); k++)
            chk($sformatf("%s_y%0d", tag, k), yq[by+k], ref_pix(k / OW, k % OW));
    endtask

    initial begin
        logic [OUTW-1:0] yd, e4;
        logic [XAW-1:0]  xa;
        logic [FAW-1:0]  fa;
        int              w;

        reset = 1'b0; start = 1'b0; y_ready = 1'b1;
        fill_random();
        repeat (2) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_y_valid", y_valid, 1'b0);
        chk("rst_y_data", y_data, '0);
        chk("rst_x_addr", x_addr, '0);
        chk("rst_f_addr", f_addr, '0);
        chk("rst_strobes", {mac_init_acc, mac_input_valid}, 2'b00);
        reset = 1'b1;
        tick();

        // Reset asserted in the middle of ISSUE
        start_run("t1");
        repeat (4) tick();
        chk("t1_mid_issue_valid", mac_input_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("t1_async_busy", busy, 1'b0);
        chk("t1_async_valid", mac_input_valid, 1'b0);
        chk("t1_async_init", mac_init_acc, 1'b0);
        chk("t1_async_x_addr", x_addr, '0);
        chk("t1_async_f_addr", f_addr, '0);
        chk("t1_async_y", {y_valid, y_data}, '0);
        repeat (8) tick();
        reset = 1'b1;
        tick();

        // All-ones image and filter: every output 9, fixed pixel period
        for (int a = 0; a < IMG_H*IMG_W; a++) xm[a] = 1;
        for (int a = 0; a < K*K; a++) fm[a] = 1;
        bias = '0;
        start_run("t2");
        finish_run(0, "t2");
        check_results("t2");
        for (int k = 0; k < NPIX && by + k < yq.size(); k++) begin
            chk($sformatf("t2_nine%0d", k), yq[by+k], 48'd9);
            if (k > 0) chk($sformatf("t2_gap%0d", k), tq[by+k] - tq[by+k-1], PERIOD);
        end

        // Centre-tap filter picks out the window centre
        for (int a = 0; a < IMG_H*IMG_W; a++) xm[a] = INW'(a);
        for (int a = 0; a < K*K; a++) fm[a] = (a == 4) ? 1 : 0;
        bias = 24'd5;
        start_run("t3");
        finish_run(0, "t3");
        check_results("t3");
        for (int k = 0; k < NPIX && by + k < yq.size(); k++)
            chk($sformatf("t3_centre%0d", k), yq[by+k], 8*(k/OW + 1) + (k%OW + 1) + 5);

        // Most-negative operand exercises sign extension end to end
        for (int a = 0; a < IMG_H*IMG_W; a++) xm[a] = -24'sd8388608;
        for (int a = 0; a < K*K; a++) fm[a] = 1;
        bias = '1;
        e4 = -48'sd75497473;
        start_run("t4");
        finish_run(0, "t4");
        check_results("t4");
        for (int k = 0; k < NPIX && by + k < yq.size(); k++)
            chk($sformatf("t4_neg%0d", k), yq[by+k], e4);

        // Stall the first output for 20 cycles, then random backpressure
        fill_random();
        y_ready = 1'b0;
        start_run("t5");
        w = 0;
        while (y_valid !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        chk("t5_first_valid", y_valid, 1'b1);
        chk("t5_first_value", y_data, ref_pix(0, 0));
        yd = y_data; xa = x_addr; fa = f_addr;
        for (int s = 0; s < 20; s++) begin
            tick();
            chk($sformatf("t5_hold_valid%0d", s), y_valid, 1'b1);
            chk($sformatf("t5_hold_data%0d", s), y_data, yd);
            chk($sformatf("t5_hold_addr%0d", s), {x_addr, f_addr}, {xa, fa});
            chk($sformatf("t5_hold_strobes%0d", s), {mac_init_acc, mac_input_valid}, 2'b00);
        end
        finish_run(1, "t5");
        check_results("t5");

        // Start pulses while busy and in the DONE cycle are ignored
        fill_random();
        start_run("t6");
        finish_run(2, "t6");
        repeat (20) tick();
        chk("t6_idle_after", busy, 1'b0);
        check_results("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
